// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit 7-segment display.
// Each digit slot is a short dark window followed by a drive window; the data shown is double-buffered per frame.
module seg_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] digit_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  logic [1:0]          state_r;
  logic [CW-1:0]       cnt_r;
  logic [IW-1:0]       idx_r;
  logic [1:0]          nxt_state_s;
  logic [CW-1:0]       nxt_cnt_s;
  logic [IW-1:0]       nxt_idx_s;

  logic [4*NDIG-1:0]   pend_r;
  logic [NDIG-1:0]     pend_dp_r;
  logic                pend_valid_r;
  logic [4*NDIG-1:0]   shadow_r;
  logic [NDIG-1:0]     shadow_dp_r;

  logic [NDIG-1:0]     lz_s;
  logic                zrun_s;
  logic [3:0]          sel_dig_s;
  logic [6:0]          seg_drive_s;
  logic                dp_sel_s;

  function automatic logic [6:0] dec7(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Slot sequencer: cnt runs continuously through blank then drive windows of one slot.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_idx_s   = idx_r;
    if (!en) begin
      nxt_state_s = IDLE;
      nxt_cnt_s   = {CW{1'b0}};
      nxt_idx_s   = {IW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          nxt_state_s = BLANK;
          nxt_cnt_s   = {CW{1'b0}};
          nxt_idx_s   = {IW{1'b0}};
        end
        BLANK: begin
          nxt_cnt_s = cnt_r + 1'b1;
          if (cnt_r == CW'(BLANK_CYC - 1)) begin
            nxt_state_s = DRIVE;
          end else begin
            nxt_state_s = BLANK;
          end
        end
        DRIVE: begin
          if (cnt_r == CW'(SCAN_DIV - 1)) begin
            nxt_state_s = BLANK;
            nxt_cnt_s   = {CW{1'b0}};
            nxt_idx_s   = (idx_r == IW'(NDIG - 1)) ? {IW{1'b0}} : idx_r + 1'b1;
          end else begin
            nxt_state_s = DRIVE;
            nxt_cnt_s   = cnt_r + 1'b1;
          end
        end
        default: begin
          nxt_state_s = IDLE;
          nxt_cnt_s   = {CW{1'b0}};
          nxt_idx_s   = {IW{1'b0}};
        end
      endcase
    end
  end

  // Leading-zero mask: a digit above 0 goes dark when it and every higher digit are zero.
  always_comb begin
    zrun_s = blank_lz;
    lz_s   = {NDIG{1'b0}};
    for (int i = NDIG - 1; i > 0; i--) begin
      zrun_s  = zrun_s && (shadow_r[4*i +: 4] == 4'h0);
      lz_s[i] = zrun_s;
    end
  end

  // Segment/dp pattern for the digit about to be driven.
  always_comb begin
    sel_dig_s   = shadow_r[{nxt_idx_s, 2'b00} +: 4];
    dp_sel_s    = shadow_dp_r[nxt_idx_s];
    seg_drive_s = lz_s[nxt_idx_s] ? 7'b0000000 : dec7(sel_dig_s);
  end

  // Sequencer state and registered outputs, both taken from the next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      idx_r      <= {IW{1'b0}};
      seg        <= 7'b0000000;
      dp         <= 1'b0;
      an         <= {NDIG{1'b0}};
      frame_done <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
      idx_r   <= nxt_idx_s;
      if (nxt_state_s == DRIVE) begin
        an  <= {{(NDIG-1){1'b0}}, 1'b1} << nxt_idx_s;
        seg <= seg_drive_s;
        dp  <= dp_sel_s;
      end else begin
        an  <= {NDIG{1'b0}};
        seg <= 7'b0000000;
        dp  <= 1'b0;
      end
      frame_done <= (nxt_state_s == DRIVE) && (nxt_idx_s == IW'(NDIG - 1)) &&
                    (nxt_cnt_s == CW'(SCAN_DIV - 1));
    end
  end

  // Pending/shadow buffers; shadow only moves on the last clock of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r       <= {NDIG{4'hF}};
      pend_dp_r    <= {NDIG{1'b0}};
      pend_valid_r <= 1'b0;
      shadow_r     <= {NDIG{4'hF}};
      shadow_dp_r  <= {NDIG{1'b0}};
    end else begin
      if (frame_done && pend_valid_r) begin
        shadow_r    <= pend_r;
        shadow_dp_r <= pend_dp_r;
      end else begin
        shadow_r    <= shadow_r;
        shadow_dp_r <= shadow_dp_r;
      end
      if (load) begin
        pend_r       <= digit_in;
        pend_dp_r    <= dp_in;
        pend_valid_r <= 1'b1;
      end else if (frame_done && pend_valid_r) begin
        pend_valid_r <= 1'b0;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NDIG=4, SCAN_DIV=16, BLANK_CYC=2).
// Vector table drives loads; expected per-digit patterns queue up and are popped as each slot is driven.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] digit_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_ctrl #(.NDIG(4), .SCAN_DIV(16), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digit_in(digit_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dps;
    logic            lz;
    logic [3:0][6:0] segs;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  vec_t vecs [6];
  exp_t sbq [$];
  int checks = 0;
  int errors = 0;
  logic [3:0][6:0] prev_segs;
  logic [3:0]      prev_dps;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_fd(output int n);
    bit found;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL fd_timeout actual=no_frame_done expected=frame_done within 200 clocks");
    end
  endtask

  task automatic push_frame(input logic [3:0][6:0] s, input logic [3:0] d);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.an  = 4'b0001 << k;
      e.seg = s[k];
      e.dp  = d[k];
      sbq.push_back(e);
    end
  endtask

  // Called at the frame_done negedge; walks one full frame and ends on the next frame_done.
  task automatic check_frame(input string tag);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      chk({tag, "_blank_an"}, {28'd0, an}, 32'd0);
      tick();
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb_empty actual=empty expected=entry", tag);
      end else begin
        e = sbq.pop_front();
        chk({tag, "_an"}, {28'd0, an}, {28'd0, e.an});
        chk({tag, "_seg"}, {25'd0, seg}, {25'd0, e.seg});
        chk({tag, "_dp"}, {31'd0, dp}, {31'd0, e.dp});
      end
      repeat (13) tick();
    end
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd1);
  endtask

  initial begin
    int n;
    bit seen;
    vecs[0] = '{digits:16'h4321, dps:4'b0000, lz:1'b0,
                segs:{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000}};
    vecs[1] = '{digits:16'h00A7, dps:4'b0000, lz:1'b1,
                segs:{7'b0000000, 7'b0000000, 7'b0000000, 7'b1110000}};
    vecs[2] = '{digits:16'h00A7, dps:4'b0000, lz:1'b0,
                segs:{7'b1111110, 7'b1111110, 7'b0000000, 7'b1110000}};
    vecs[3] = '{digits:16'h0000, dps:4'b0100, lz:1'b1,
                segs:{7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
    vecs[4] = '{digits:16'h9865, dps:4'b1001, lz:1'b1,
                segs:{7'b1111011, 7'b1111111, 7'b1011111, 7'b1011011}};
    vecs[5] = '{digits:16'h0102, dps:4'b0010, lz:1'b1,
                segs:{7'b0000000, 7'b0110000, 7'b1111110, 7'b1101101}};

    rst = 1'b1; en = 1'b0; load = 1'b0; digit_in = 16'h0000; dp_in = 4'b0000; blank_lz = 1'b0;
    repeat (3) tick();
    chk("rst_seg", {25'd0, seg}, 32'd0);
    chk("rst_an", {28'd0, an}, 32'd0);
    chk("rst_dp", {31'd0, dp}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_an", {28'd0, an}, 32'd0);

    // Blank shadow after reset; first frame_done 64 clocks after enable.
    en = 1'b1;
    wait_fd(n);
    chk("first_frame_len", n, 32'd64);
    prev_segs = '0;
    prev_dps  = 4'b0000;
    push_frame(prev_segs, prev_dps);
    check_frame("blank");
    wait_fd(n);
    chk("frame_period", n, 32'd64);

    for (int v = 0; v < 6; v++) begin
      repeat (20) tick();
      digit_in = vecs[v].digits;
      dp_in    = vecs[v].dps;
      load     = 1'b1;
      push_frame(vecs[v].segs, vecs[v].dps);
      tick();
      load = 1'b0;
      repeat (14) tick();
      chk("midframe_an", {28'd0, an}, 32'h4);
      chk("midframe_old_seg", {25'd0, seg}, {25'd0, prev_segs[2]});
      chk("midframe_old_dp", {31'd0, dp}, {31'd0, prev_dps[2]});
      blank_lz = vecs[v].lz;
      wait_fd(n);
      check_frame("vec");
      prev_segs = vecs[v].segs;
      prev_dps  = vecs[v].dps;
    end

    // Load on the frame_done clock: the following frame still shows the previous value.
    digit_in = 16'h7777;
    dp_in    = 4'b1111;
    load     = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("fdload_old_an", {28'd0, an}, 32'h1);
    chk("fdload_old_seg", {25'd0, seg}, {25'd0, prev_segs[0]});
    chk("fdload_old_dp", {31'd0, dp}, {31'd0, prev_dps[0]});
    push_frame({4{7'b1110000}}, 4'b1111);
    prev_segs = {4{7'b1110000}};
    prev_dps  = 4'b1111;
    wait_fd(n);
    check_frame("fdload_new");

    // Drop en while digit2 is driven, then resume.
    repeat (36) tick();
    chk("pre_dis_an", {28'd0, an}, 32'h4);
    en = 1'b0;
    tick();
    chk("dis_an", {28'd0, an}, 32'd0);
    chk("dis_seg", {25'd0, seg}, 32'd0);
    chk("dis_dp", {31'd0, dp}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (frame_done || (an != 4'b0000)) seen = 1'b1;
    end
    chk("dis_dark", {31'd0, seen}, 32'd0);
    en = 1'b1;
    tick();
    chk("resume_blank0", {28'd0, an}, 32'd0);
    tick();
    chk("resume_blank1", {28'd0, an}, 32'd0);
    tick();
    chk("resume_an", {28'd0, an}, 32'h1);
    chk("resume_seg", {25'd0, seg}, {25'd0, prev_segs[0]});

    // Async reset mid-drive, away from the clock edge.
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_an", {28'd0, an}, 32'd0);
    chk("arst_seg", {25'd0, seg}, 32'd0);
    chk("arst_fd", {31'd0, frame_done}, 32'd0);
    tick();
    rst = 1'b0;
    push_frame('0, 4'b0000);
    wait_fd(n);
    chk("arst_frame_len", n, 32'd64);
    check_frame("arst_blank");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
